// File: rtl/mem_pkg.sv
// Shared FSM state type and line/beat geometry helpers for the bulk line serializer.
// Pure declarations: no logic, no latency, no flow control.
package mem_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} ser_state_t;

  // Upper bound on LINE_SIZE supported by the beat search below.
  localparam int MAX_BEATS = 64;

  function automatic int beat_bytes(input int data_w);
    return data_w / 8;
  endfunction

  function automatic int line_offset_bits(input int data_w, input int line_size);
    return $clog2(line_size * (data_w / 8));
  endfunction

  // Lowest set mask bit strictly above idx; MAX_BEATS when no beat remains.
  function automatic int next_active_beat(input logic [MAX_BEATS-1:0] mask, input int idx);
    int r;
    r = MAX_BEATS;
    for (int i = MAX_BEATS - 1; i >= 0; i--) begin
      if (i > idx && mask[i]) r = i;
    end
    return r;
  endfunction

endpackage

// File: rtl/bulk_read_interface.sv
// Line-granular request/response port between cache refill/writeback logic and the memory side.
// One line in flight; resp_valid is a single-cycle pulse with no back-pressure.
interface bulk_read_interface #(
  parameter int DATA_W    = 64,
  parameter int ADDR_W    = 64,
  parameter int LINE_SIZE = 16
);

  logic                                   req_valid;
  logic                                   req_ready;
  logic [ADDR_W-1:0]                      req_addr;
  logic                                   req_write;
  logic [LINE_SIZE-1:0][DATA_W-1:0]       req_wdata;
  logic [LINE_SIZE-1:0][DATA_W/8-1:0]     req_wstrb;
  logic                                   dumping_cache;
  logic                                   resp_valid;
  logic [LINE_SIZE-1:0][DATA_W-1:0]       resp_rdata;

  modport master (
    output req_valid, req_addr, req_write, req_wdata, req_wstrb, dumping_cache,
    input  req_ready, resp_valid, resp_rdata
  );

  modport slave (
    input  req_valid, req_addr, req_write, req_wdata, req_wstrb, dumping_cache,
    output req_ready, resp_valid, resp_rdata
  );

endinterface

// File: rtl/bulk_line_serializer.sv
// Splits a line request into single-word memory transactions, one outstanding; line done 2*beats+1 cycles after accept.
// Waits on mem_req_ready with the request held stable; req_ready only in IDLE; resp_valid pulse has no back-pressure.
module bulk_line_serializer
  import mem_pkg::*;
#(
  parameter int DATA_W    = 64,
  parameter int ADDR_W    = 64,
  parameter int LINE_SIZE = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  bulk_read_interface.slave     bulk,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_W-1:0]     mem_req_addr,
  output logic                  mem_req_write,
  output logic [DATA_W-1:0]     mem_req_wdata,
  output logic [DATA_W/8-1:0]   mem_req_wstrb,
  input  logic                  mem_resp_valid,
  input  logic [DATA_W-1:0]     mem_resp_rdata
);

  localparam int BEAT_BYTES = beat_bytes(DATA_W);
  localparam int OFS_W      = line_offset_bits(DATA_W, LINE_SIZE);
  localparam int IDX_W      = $clog2(LINE_SIZE);

  typedef logic [LINE_SIZE-1:0][DATA_W-1:0]     line_t;
  typedef logic [LINE_SIZE-1:0][BEAT_BYTES-1:0] strb_t;

  ser_state_t           state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [ADDR_W-1:0]    base_q, base_d;
  logic                 write_q, write_d;
  line_t                wdata_q, wdata_d;
  line_t                rbuf_q, rbuf_d;
  strb_t                wstrb_q, wstrb_d;
  logic [MAX_BEATS-1:0] req_mask, run_mask;
  int                   first_beat, next_beat;

  // Sequencing does not depend on whether the cache is dumping.
  wire unused_dumping = bulk.dumping_cache;

  // A beat is active for every read word, and for write words with any byte enabled.
  always_comb begin
    req_mask = '0;
    run_mask = '0;
    for (int i = 0; i < LINE_SIZE; i++) begin
      req_mask[i] = !bulk.req_write || (|bulk.req_wstrb[i]);
      run_mask[i] = !write_q || (|wstrb_q[i]);
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    base_d     = base_q;
    write_d    = write_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    rbuf_d     = rbuf_q;
    first_beat = next_active_beat(req_mask, -1);
    next_beat  = next_active_beat(run_mask, int'(idx_q));
    case (state_q)
      IDLE: begin
        if (bulk.req_valid) begin
          base_d            = bulk.req_addr;
          base_d[OFS_W-1:0] = '0;
          write_d           = bulk.req_write;
          wdata_d           = bulk.req_wdata;
          wstrb_d           = bulk.req_wstrb;
          if (first_beat < LINE_SIZE) begin
            idx_d   = IDX_W'(first_beat);
            state_d = ISSUE;
          end else begin
            idx_d   = '0;
            state_d = DONE;
          end
        end
      end
      ISSUE: begin
        if (mem_req_ready) state_d = WAIT;
      end
      WAIT: begin
        if (mem_resp_valid) begin
          if (!write_q) rbuf_d[idx_q] = mem_resp_rdata;
          if (next_beat < LINE_SIZE) begin
            idx_d   = IDX_W'(next_beat);
            state_d = ISSUE;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      base_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rbuf_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      base_q  <= base_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      rbuf_q  <= rbuf_d;
    end
  end

  assign bulk.req_ready  = (state_q == IDLE);
  assign bulk.resp_valid = (state_q == DONE);
  assign bulk.resp_rdata = rbuf_q;
  assign mem_req_valid   = (state_q == ISSUE);
  assign mem_req_addr    = base_q + ADDR_W'(idx_q) * ADDR_W'(BEAT_BYTES);
  assign mem_req_write   = write_q;
  assign mem_req_wdata   = wdata_q[idx_q];
  assign mem_req_wstrb   = wstrb_q[idx_q];

endmodule

// File: tb/tb_bulk_line_serializer.sv
// Scoreboarded bench for bulk_line_serializer: a memory model checks each word request against
// expected beats, a response monitor checks the returned line and its latency.
module tb_bulk_line_serializer;

  localparam int DATA_W    = 64;
  localparam int ADDR_W    = 64;
  localparam int LINE_SIZE = 16;
  localparam int BB        = DATA_W / 8;

  typedef logic [LINE_SIZE-1:0][DATA_W-1:0] line_t;
  typedef logic [LINE_SIZE-1:0][BB-1:0]     strb_t;
  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic              write;
    logic [DATA_W-1:0] wdata;
    logic [BB-1:0]     wstrb;
  } beat_t;
  typedef struct {
    line_t rdata;
    int    nbeats;
    int    extra0;
  } resp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bulk_read_interface #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LINE_SIZE(LINE_SIZE)) bulk ();

  logic              mem_req_valid;
  logic              mem_req_ready = 1'b0;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_req_write;
  logic [DATA_W-1:0] mem_req_wdata;
  logic [BB-1:0]     mem_req_wstrb;
  logic              mem_resp_valid = 1'b0;
  logic [DATA_W-1:0] mem_resp_rdata = '0;

  bulk_line_serializer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LINE_SIZE(LINE_SIZE)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bulk           (bulk),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_req_write  (mem_req_write),
    .mem_req_wdata  (mem_req_wdata),
    .mem_req_wstrb  (mem_req_wstrb),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_rdata (mem_resp_rdata)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  beat_t exp_beats[$];
  resp_t exp_resp[$];
  line_t rbuf_m = '0;

  // Memory-model state and directed controls.
  int   beats_total = 0;
  int   extra_total = 0;
  int   pend = 0, pend_delay = 0, stall_left = -1;
  bit   hs_sched = 1'b0, pend_write = 1'b0;
  logic [ADDR_W-1:0] pend_addr = '0;
  bit   rand_mode = 1'b0, spur_en = 1'b0;
  int   dir_stall_at = -1, dir_stall_len = 0, dir_hold_at = -1;

  // Response monitor results.
  int resp_seen = 0;
  int last_lat  = 0;
  int acc_cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_line(input string nm, input line_t act, input line_t exp);
    int first;
    first = -1;
    total++;
    for (int k = LINE_SIZE - 1; k >= 0; k--) if (act[k] !== exp[k]) first = k;
    if (first >= 0) begin
      bad++;
      $display("FAIL %s word %0d: got %h expected %h", nm, first, act[first], exp[first]);
    end
  endtask

  // Word memory: read data equals the byte address; one transaction outstanding.
  always @(negedge clk) begin
    if (!rst_n) begin
      pend = 0; pend_delay = 0; hs_sched = 1'b0; stall_left = -1;
      mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = '0;
    end else begin
      mem_resp_valid = 1'b0;
      mem_resp_rdata = '0;
      if (hs_sched) begin
        hs_sched = 1'b0;
        pend     = 1;
        if (beats_total == dir_hold_at) pend_delay = 1000;
        else pend_delay = rand_mode ? $urandom_range(0, 2) : 0;
        if (pend_delay < 1000) extra_total += pend_delay;
        beats_total++;
      end
      if (pend != 0) begin
        if (pend_delay == 0) begin
          mem_resp_valid = 1'b1;
          mem_resp_rdata = pend_write ? {$urandom, $urandom} : pend_addr;
          pend = 0;
        end else begin
          pend_delay--;
        end
      end else if (spur_en && $urandom_range(0, 2) == 0) begin
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 64'hDEAD;
      end
      if (mem_req_valid) begin
        if (stall_left < 0) begin
          if (beats_total == dir_stall_at) stall_left = dir_stall_len;
          else stall_left = rand_mode ? $urandom_range(0, 2) : 0;
        end
        if (exp_beats.size() == 0) begin
          total++; bad++;
          $display("FAIL beat_unexpected: got request addr %h, required no request", mem_req_addr);
        end else begin
          chk("beat_addr",  mem_req_addr, exp_beats[0].addr);
          chk("beat_write", 64'(mem_req_write), 64'(exp_beats[0].write));
          chk("beat_wdata", mem_req_wdata, exp_beats[0].wdata);
          chk("beat_wstrb", 64'(mem_req_wstrb), 64'(exp_beats[0].wstrb));
        end
        if (stall_left > 0) begin
          mem_req_ready = 1'b0;
          stall_left--;
          extra_total++;
        end else begin
          mem_req_ready = 1'b1;
          hs_sched      = 1'b1;
          stall_left    = -1;
          pend_addr     = mem_req_addr;
          pend_write    = mem_req_write;
          if (exp_beats.size() != 0) exp_beats.delete(0);
        end
      end else begin
        mem_req_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  // Line response monitor: contents from the model, latency 2*beats+1 plus inserted waits.
  always @(negedge clk) begin
    resp_t r;
    if (rst_n && bulk.resp_valid) begin
      resp_seen++;
      last_lat = cyc - acc_cyc;
      if (exp_resp.size() == 0) begin
        total++; bad++;
        $display("FAIL resp_unexpected: got resp_valid=1, required 0");
      end else begin
        r = exp_resp.pop_front();
        chk_line("resp_rdata", bulk.resp_rdata, r.rdata);
        chk("resp_latency", 64'(last_lat), 64'(2 * r.nbeats + 1 + (extra_total - r.extra0)));
      end
    end
  end

  task automatic do_line(input logic [ADDR_W-1:0] addr, input logic wr, input line_t wd,
                         input strb_t ws, input bit wait_resp);
    logic [ADDR_W-1:0] base;
    beat_t b;
    resp_t r;
    int n, seen0, t;
    base = addr;
    base[6:0] = '0;
    n = 0;
    for (int k = 0; k < LINE_SIZE; k++) begin
      if (!wr || ws[k] != '0) begin
        b.addr  = base + ADDR_W'(k * BB);
        b.write = wr;
        b.wdata = wd[k];
        b.wstrb = ws[k];
        exp_beats.push_back(b);
        n++;
        if (!wr) rbuf_m[k] = b.addr;
      end
    end
    r.rdata  = rbuf_m;
    r.nbeats = n;
    r.extra0 = extra_total;
    exp_resp.push_back(r);
    seen0 = resp_seen;
    @(negedge clk); #1;
    bulk.req_valid     = 1'b1;
    bulk.req_addr      = addr;
    bulk.req_write     = wr;
    bulk.req_wdata     = wd;
    bulk.req_wstrb     = ws;
    bulk.dumping_cache = 1'($urandom_range(0, 1));
    t = 0;
    while (!bulk.req_ready && t < 20) begin @(negedge clk); #1; t++; end
    chk("req_ready_idle", 64'(bulk.req_ready), 64'd1);
    acc_cyc = cyc;
    @(negedge clk); #1;
    bulk.req_valid = 1'b0;
    bulk.req_addr  = {$urandom, $urandom};
    for (int k = 0; k < LINE_SIZE; k++) begin
      bulk.req_wdata[k] = {$urandom, $urandom};
      bulk.req_wstrb[k] = 8'($urandom);
    end
    chk("req_ready_busy", 64'(bulk.req_ready), 64'd0);
    if (wait_resp) begin
      t = 0;
      while (resp_seen == seen0 && t < 600) begin @(negedge clk); #1; t++; end
      if (resp_seen == seen0) begin
        total++; bad++;
        $display("FAIL resp_timeout: got no resp_valid, required one");
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    line_t wd;
    strb_t ws;
    int b0, t;
    bulk.req_valid = 1'b0; bulk.req_addr = '0; bulk.req_write = 1'b0;
    bulk.req_wdata = '0; bulk.req_wstrb = '0; bulk.dumping_cache = 1'b0;
    #2;
    chk("rst_req_ready",  64'(bulk.req_ready), 64'd1);
    chk("rst_req_valid",  64'(mem_req_valid), 64'd0);
    chk("rst_resp_valid", 64'(bulk.resp_valid), 64'd0);
    chk("rst_req_addr",   mem_req_addr, 64'd0);
    chk("rst_req_write",  64'(mem_req_write), 64'd0);
    chk("rst_req_wstrb",  64'(mem_req_wstrb), 64'd0);
    chk_line("rst_resp_rdata", bulk.resp_rdata, '0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;

    for (int k = 0; k < LINE_SIZE; k++) wd[k] = {32'hA000_0000 + 32'(k), $urandom};

    // Full line read, zero-wait memory.
    do_line(64'h1234, 1'b0, wd, '0, 1'b1);
    chk("read_latency", 64'(last_lat), 64'd33);

    // Sparse write: two beats only.
    ws = '0; ws[3] = 8'hFF; ws[9] = 8'h0F;
    do_line(64'h8000_0000_0000_0040, 1'b1, wd, ws, 1'b1);
    chk("sparse_latency", 64'(last_lat), 64'd5);

    // Write with no enabled bytes: no memory traffic.
    do_line(64'h2000, 1'b1, wd, '0, 1'b1);
    chk("empty_latency", 64'(last_lat), 64'd1);

    // Beat 5 held off by memory for three cycles.
    dir_stall_at = beats_total + 5; dir_stall_len = 3;
    do_line(64'h3000, 1'b0, wd, '0, 1'b1);
    chk("stall_latency", 64'(last_lat), 64'd36);
    dir_stall_at = -1;

    // Stray responses outside WAIT.
    spur_en = 1'b1;
    do_line(64'h5588, 1'b0, wd, '0, 1'b1);
    chk("spurious_latency", 64'(last_lat), 64'd33);
    spur_en = 1'b0;

    // Reset while waiting on beat 7.
    b0 = beats_total;
    dir_hold_at = b0 + 7;
    do_line(64'h4000, 1'b0, wd, '0, 1'b0);
    t = 0;
    while (beats_total != b0 + 8 && t < 100) begin @(negedge clk); #1; t++; end
    chk("rst_reached_wait", 64'(beats_total), 64'(b0 + 8));
    rst_n = 1'b0;
    #1;
    chk("midrst_req_valid",  64'(mem_req_valid), 64'd0);
    chk("midrst_resp_valid", 64'(bulk.resp_valid), 64'd0);
    chk_line("midrst_rbuf", bulk.resp_rdata, '0);
    exp_beats.delete();
    exp_resp.delete();
    rbuf_m = '0;
    dir_hold_at = -1;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    chk("postrst_req_ready", 64'(bulk.req_ready), 64'd1);
    repeat (3) begin
      @(negedge clk); #1;
      chk("postrst_idle", 64'(mem_req_valid), 64'd0);
    end
    do_line(64'h4000, 1'b0, wd, '0, 1'b1);
    chk("postrst_latency", 64'(last_lat), 64'd33);

    // Randomized lines with random stalls, response delays and stray responses.
    rand_mode = 1'b1;
    spur_en   = 1'b1;
    for (int n = 0; n < 20; n++) begin
      for (int k = 0; k < LINE_SIZE; k++) begin
        wd[k] = {$urandom, $urandom};
        ws[k] = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      end
      do_line({$urandom, $urandom}, 1'($urandom_range(0, 1)), wd, ws, 1'b1);
    end

    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
